// File: rtl/shift_reg2d_pkg.sv
// rtl/shift_reg2d_pkg.sv - shared types and defaults for the 2D shift register frame controller
package shift_reg2d_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/shift_reg2d_frame_ctrl_rr_arb2.sv
// rtl/shift_reg2d_frame_ctrl_rr_arb2.sv - two-way round-robin arbiter, one-hot grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // on a tie the requester that did not own the last frame wins
            2'b11:   grant = last_owner ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/shift_reg2d_frame_ctrl.sv
// rtl/shift_reg2d_frame_ctrl.sv - frame sequencer and two-requester arbiter for the 2D shift register
module shift_reg2d_frame_ctrl
    import shift_reg2d_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ0_VALID,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    input  logic              CLEAR,
    input  logic              FRAME_ACK,
    output logic              SHIFT_EN,
    output logic [DATA_W-1:0] SHIFT_DATA,
    output logic [CNT_W-1:0]  FILL_COUNT,
    output logic              FRAME_VALID,
    output logic              FRAME_SRC,
    output logic              BUSY
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              src_q, src_d;
    logic              last_q, last_d;
    logic [1:0]        rdy_q, rdy_d;
    logic [1:0]        grant;
    logic              owner_valid;
    logic [DATA_W-1:0] owner_data;
    logic              hs;

    rr_arb2 u_arb (
        .req        ({REQ1_VALID, REQ0_VALID}),
        .last_owner (last_q),
        .grant      (grant)
    );

    assign owner_valid = src_q ? REQ1_VALID : REQ0_VALID;
    assign owner_data  = src_q ? REQ1_DATA  : REQ0_DATA;
    // a CLEAR in FILL wins over any word offered in the same cycle
    assign hs          = (state_q == ST_FILL) && owner_valid && rdy_q[src_q] && !CLEAR;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            flush_q <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            rdy_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            flush_q <= flush_d;
            src_q   <= src_d;
            last_q  <= last_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        flush_d    = flush_q;
        src_d      = src_q;
        last_d     = last_q;
        rdy_d      = rdy_q;
        SHIFT_EN   = 1'b0;
        SHIFT_DATA = '0;
        case (state_q)
            ST_IDLE: begin
                if (CLEAR) begin
                    state_d = ST_FLUSH;
                    flush_d = '0;
                    rdy_d   = 2'b00;
                end else if (grant != 2'b00) begin
                    state_d = ST_FILL;
                    src_d   = grant[1];
                    rdy_d   = grant;
                    fill_d  = '0;
                end
            end
            ST_FILL: begin
                if (CLEAR) begin
                    state_d = ST_FLUSH;
                    fill_d  = '0;
                    flush_d = '0;
                    rdy_d   = 2'b00;
                end else if (hs) begin
                    SHIFT_EN   = 1'b1;
                    SHIFT_DATA = owner_data;
                    fill_d     = fill_q + CNT_W'(1);
                    if (fill_q == LAST_IDX) begin
                        state_d = ST_HOLD;
                        rdy_d   = 2'b00;
                    end
                end
            end
            ST_HOLD: begin
                // a CLEAR also consumes the held frame, so ownership is recorded either way
                if (CLEAR || FRAME_ACK) begin
                    last_d  = src_q;
                    fill_d  = '0;
                    flush_d = '0;
                    state_d = CLEAR ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                SHIFT_EN = 1'b1;
                if (flush_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    flush_d = '0;
                end else begin
                    flush_d = flush_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign REQ0_READY  = rdy_q[0] && !CLEAR;
    assign REQ1_READY  = rdy_q[1] && !CLEAR;
    assign FILL_COUNT  = fill_q;
    assign FRAME_VALID = (state_q == ST_HOLD);
    assign FRAME_SRC   = src_q;
    assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_reg2d_frame_ctrl.sv
// tb/tb_shift_reg2d_frame_ctrl.sv - self-checking bench for shift_reg2d_frame_ctrl
module tb_shift_reg2d_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic       REQ0_VALID = 1'b0;
    logic [3:0] REQ0_DATA = 4'h0;
    logic       REQ0_READY;
    logic       REQ1_VALID = 1'b0;
    logic [3:0] REQ1_DATA = 4'h0;
    logic       REQ1_READY;
    logic       CLEAR = 1'b0;
    logic       FRAME_ACK = 1'b0;
    logic       SHIFT_EN;
    logic [3:0] SHIFT_DATA;
    logic [4:0] FILL_COUNT;
    logic       FRAME_VALID;
    logic       FRAME_SRC;
    logic       BUSY;

    shift_reg2d_frame_ctrl dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .REQ0_VALID  (REQ0_VALID),
        .REQ0_DATA   (REQ0_DATA),
        .REQ0_READY  (REQ0_READY),
        .REQ1_VALID  (REQ1_VALID),
        .REQ1_DATA   (REQ1_DATA),
        .REQ1_READY  (REQ1_READY),
        .CLEAR       (CLEAR),
        .FRAME_ACK   (FRAME_ACK),
        .SHIFT_EN    (SHIFT_EN),
        .SHIFT_DATA  (SHIFT_DATA),
        .FILL_COUNT  (FILL_COUNT),
        .FRAME_VALID (FRAME_VALID),
        .FRAME_SRC   (FRAME_SRC),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       v0;
        logic [3:0] d0;
        logic       ack;
        logic       r0;
        logic [4:0] fill;
        logic       fv;
        logic       busy;
        logic       src;
    } vec_t;

    vec_t       vt[20];
    int         n_pass = 0;
    int         n_total = 0;
    int         sh_cnt = 0;
    logic       fv_seen = 1'b0;
    logic [3:0] sb_q[$];
    logic [3:0] taps[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // downstream array as the real register would see it; taps[0] holds the newest word
    always @(posedge CLK) begin
        if (SHIFT_EN) begin
            for (int i = 15; i > 0; i--) taps[i] <= taps[i-1];
            taps[0] <= SHIFT_DATA;
        end
    end

    always @(negedge CLK) begin
        if (RESET_N) begin
            if (SHIFT_EN) begin
                sh_cnt++;
                if (sb_q.size() == 0) check("sb_unexpected_shift", 32'(sb_q.size()), 32'd1);
                else check("sb_shift_data", 32'(SHIFT_DATA), 32'(sb_q.pop_front()));
            end else begin
                check("data_zero_when_idle", 32'(SHIFT_DATA), 32'd0);
            end
        end
    end

    task automatic next_drive();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_zeros();
        for (int i = 0; i < 16; i++) sb_q.push_back(4'h0);
    endtask

    task automatic wait_idle(input int budget);
        int cycles;
        cycles = 0;
        while (cycles < budget) begin
            @(negedge CLK);
            if (!BUSY) break;
            if (FRAME_VALID) fv_seen = 1'b1;
            cycles++;
        end
        check("wait_idle_in_budget", 32'(cycles < budget), 32'd1);
        next_drive();
    endtask

    task automatic run_frame(input logic v0, input logic v1, input logic exp_owner, input logic [3:0] base);
        REQ0_VALID = v0;
        REQ1_VALID = v1;
        @(negedge CLK);
        check("grant_cycle_r0", 32'(REQ0_READY), 32'd0);
        check("grant_cycle_r1", 32'(REQ1_READY), 32'd0);
        next_drive();
        for (int i = 0; i < 16; i++) begin
            REQ0_DATA = base + 4'(i);
            REQ1_DATA = ~(base + 4'(i));
            sb_q.push_back(exp_owner ? REQ1_DATA : REQ0_DATA);
            @(negedge CLK);
            check("frame_owner_ready", 32'(exp_owner ? REQ1_READY : REQ0_READY), 32'd1);
            check("frame_other_ready", 32'(exp_owner ? REQ0_READY : REQ1_READY), 32'd0);
            check("frame_src", 32'(FRAME_SRC), 32'(exp_owner));
            check("frame_fill", 32'(FILL_COUNT), 32'(i));
            next_drive();
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        @(negedge CLK);
        check("frame_hold_fv", 32'(FRAME_VALID), 32'd1);
        check("frame_hold_fill", 32'(FILL_COUNT), 32'd16);
        next_drive();
    endtask

    initial begin
        int k;
        int nhs;

        vt[0] = '{v0: 1'b1, d0: 4'h0, ack: 1'b0, r0: 1'b0, fill: 5'd0, fv: 1'b0, busy: 1'b0, src: 1'b0};
        for (int i = 1; i <= 16; i++)
            vt[i] = '{v0: 1'b1, d0: 4'(i - 1), ack: 1'b0, r0: 1'b1, fill: 5'(i - 1), fv: 1'b0, busy: 1'b1, src: 1'b0};
        vt[17] = '{v0: 1'b0, d0: 4'h0, ack: 1'b0, r0: 1'b0, fill: 5'd16, fv: 1'b1, busy: 1'b1, src: 1'b0};
        vt[18] = '{v0: 1'b0, d0: 4'h0, ack: 1'b1, r0: 1'b0, fill: 5'd16, fv: 1'b1, busy: 1'b1, src: 1'b0};
        vt[19] = '{v0: 1'b0, d0: 4'h0, ack: 1'b0, r0: 1'b0, fill: 5'd0,  fv: 1'b0, busy: 1'b0, src: 1'b0};

        #2 RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_r0", 32'(REQ0_READY), 32'd0);
        check("rst_r1", 32'(REQ1_READY), 32'd0);
        check("rst_shift_en", 32'(SHIFT_EN), 32'd0);
        check("rst_fill", 32'(FILL_COUNT), 32'd0);
        check("rst_fv", 32'(FRAME_VALID), 32'd0);
        check("rst_src", 32'(FRAME_SRC), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        RESET_N = 1'b1;
        next_drive();

        // CLEAR pulse from IDLE
        sh_cnt = 0;
        CLEAR = 1'b1;
        push_zeros();
        next_drive();
        CLEAR = 1'b0;
        wait_idle(40);
        check("clear_shift_count", 32'(sh_cnt), 32'd16);
        for (int i = 0; i < 16; i++) check("clear_tap_zero", 32'(taps[i]), 32'd0);

        // REQ0 streams 0..F back to back
        for (int i = 0; i < 20; i++) begin
            REQ0_VALID = vt[i].v0;
            REQ0_DATA  = vt[i].d0;
            FRAME_ACK  = vt[i].ack;
            if (vt[i].v0 && vt[i].r0) sb_q.push_back(vt[i].d0);
            @(negedge CLK);
            check("vec_r0", 32'(REQ0_READY), 32'(vt[i].r0));
            check("vec_r1", 32'(REQ1_READY), 32'd0);
            check("vec_fill", 32'(FILL_COUNT), 32'(vt[i].fill));
            check("vec_fv", 32'(FRAME_VALID), 32'(vt[i].fv));
            check("vec_busy", 32'(BUSY), 32'(vt[i].busy));
            check("vec_src", 32'(FRAME_SRC), 32'(vt[i].src));
            next_drive();
        end
        check("stream_tap0", 32'(taps[0]), 32'hF);
        check("stream_tap15", 32'(taps[15]), 32'h0);

        // REQ0 valid on alternate cycles
        REQ0_VALID = 1'b1;
        REQ0_DATA  = 4'h0;
        next_drive();
        k = 1;
        nhs = 0;
        while (nhs < 16 && k < 80) begin
            REQ0_VALID = k[0];
            REQ0_DATA  = 4'(nhs);
            if (REQ0_VALID) sb_q.push_back(REQ0_DATA);
            @(negedge CLK);
            check("alt_fill", 32'(FILL_COUNT), 32'(nhs));
            if (REQ0_VALID) nhs++;
            next_drive();
            k++;
        end
        check("alt_cycles", 32'(k), 32'd32);
        REQ0_VALID = 1'b0;
        @(negedge CLK);
        check("alt_hold_fv", 32'(FRAME_VALID), 32'd1);
        check("alt_hold_fill", 32'(FILL_COUNT), 32'd16);
        next_drive();
        FRAME_ACK = 1'b1;
        next_drive();
        FRAME_ACK = 1'b0;
        @(negedge CLK);
        check("alt_ack_idle", 32'(BUSY), 32'd0);
        next_drive();

        // both requesters from reset: REQ0 first, then REQ1
        RESET_N = 1'b0;
        next_drive();
        RESET_N = 1'b1;
        run_frame(1'b1, 1'b1, 1'b0, 4'h3);
        FRAME_ACK = 1'b1;
        next_drive();
        FRAME_ACK = 1'b0;
        run_frame(1'b1, 1'b1, 1'b1, 4'h8);
        FRAME_ACK = 1'b1;
        next_drive();
        FRAME_ACK = 1'b0;

        // CLEAR at FILL_COUNT = 9
        REQ0_VALID = 1'b1;
        next_drive();
        for (int i = 0; i < 9; i++) begin
            REQ0_DATA = 4'(i + 1);
            sb_q.push_back(REQ0_DATA);
            next_drive();
        end
        REQ0_DATA = 4'h9;
        CLEAR = 1'b1;
        sh_cnt = 0;
        fv_seen = 1'b0;
        push_zeros();
        @(negedge CLK);
        check("clr9_fill", 32'(FILL_COUNT), 32'd9);
        check("clr9_no_shift", 32'(SHIFT_EN), 32'd0);
        check("clr9_ready", 32'(REQ0_READY), 32'd0);
        next_drive();
        CLEAR = 1'b0;
        REQ0_VALID = 1'b0;
        @(negedge CLK);
        check("clr9_flush_busy", 32'(BUSY), 32'd1);
        check("clr9_flush_fill", 32'(FILL_COUNT), 32'd0);
        check("clr9_flush_en", 32'(SHIFT_EN), 32'd1);
        next_drive();
        wait_idle(40);
        check("clr9_shift_count", 32'(sh_cnt), 32'd16);
        check("clr9_fv_never", 32'(fv_seen), 32'd0);

        // CLEAR and FRAME_ACK together in HOLD
        run_frame(1'b1, 1'b0, 1'b0, 4'h1);
        CLEAR = 1'b1;
        FRAME_ACK = 1'b1;
        sh_cnt = 0;
        push_zeros();
        next_drive();
        CLEAR = 1'b0;
        FRAME_ACK = 1'b0;
        @(negedge CLK);
        check("hold_clr_busy", 32'(BUSY), 32'd1);
        check("hold_clr_fv", 32'(FRAME_VALID), 32'd0);
        check("hold_clr_en", 32'(SHIFT_EN), 32'd1);
        check("hold_clr_fill", 32'(FILL_COUNT), 32'd0);
        next_drive();
        wait_idle(40);
        check("hold_clr_shift_count", 32'(sh_cnt), 32'd16);

        // owner 0 was recorded by the CLEAR, so REQ1 wins the tie; then reset mid-fill
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        next_drive();
        for (int i = 0; i < 4; i++) begin
            REQ1_DATA = 4'(12 - i);
            sb_q.push_back(REQ1_DATA);
            @(negedge CLK);
            check("tie_src", 32'(FRAME_SRC), 32'd1);
            check("tie_r1", 32'(REQ1_READY), 32'd1);
            next_drive();
        end
        #2 RESET_N = 1'b0;
        #1;
        check("async_rst_fill", 32'(FILL_COUNT), 32'd0);
        check("async_rst_busy", 32'(BUSY), 32'd0);
        check("async_rst_r1", 32'(REQ1_READY), 32'd0);
        check("async_rst_en", 32'(SHIFT_EN), 32'd0);
        check("async_rst_src", 32'(FRAME_SRC), 32'd0);
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        next_drive();
        RESET_N = 1'b1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
